// File: rtl/osc_pattern_gen.sv
// Burst oscillator that drives a pattern detector's A input: BURST+1 slots of HALF_PER cycles.
// Optional macro OSC_GEN_BRK_EN adds input i_brk to suppress individual toggles.
module osc_pattern_gen #(
  parameter int unsigned HALF_PER = 2,
  parameter int unsigned BURST    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_init_lvl,
  input  logic       i_abort,
`ifdef OSC_GEN_BRK_EN
  input  logic       i_brk,
`endif
  output logic       o_a_out,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_slot_cnt
);

  localparam logic [7:0] PhaseLast = 8'(HALF_PER - 1);
  localparam logic [7:0] BurstLen  = 8'(BURST);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_phase;
  logic [7:0] r_slot_cnt;
  logic       r_a_out;
  logic       w_boundary;
  logic       w_last;
  logic       w_toggle;
  logic       w_launch;

  assign w_boundary = (r_phase == PhaseLast);
  assign w_last     = w_boundary && (r_slot_cnt == BurstLen);
  assign w_launch   = i_start && !i_abort;

`ifdef OSC_GEN_BRK_EN
  assign w_toggle = !i_brk;
`else
  assign w_toggle = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_launch) w_state_next = StRun;
      StRun: begin
        // Abort takes priority over a slot boundary on the same edge.
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_out    <= 1'b0;
      r_phase    <= 8'd0;
      r_slot_cnt <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_launch) begin
            r_a_out    <= i_init_lvl;
            r_phase    <= 8'd0;
            r_slot_cnt <= 8'd0;
          end
        end
        StRun: begin
          if (!i_abort) begin
            if (!w_boundary) begin
              r_phase <= r_phase + 8'd1;
            end else if (!w_last) begin
              // Slot count advances even when the toggle is suppressed.
              if (w_toggle) r_a_out <= !r_a_out;
              r_slot_cnt <= r_slot_cnt + 8'd1;
              r_phase    <= 8'd0;
            end else begin
              r_phase <= 8'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_busy     = (r_state == StRun);
    o_done     = (r_state == StDone);
    o_a_out    = r_a_out;
    o_slot_cnt = r_slot_cnt;
  end

endmodule

// File: tb/tb_osc_pattern_gen.sv
// Scoreboard bench for osc_pattern_gen: DUT A (HALF_PER=2, BURST=4), DUT B (HALF_PER=1, BURST=4).
module tb_osc_pattern_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       init_lvl = 1'b0;
  logic       abort = 1'b0;
`ifdef OSC_GEN_BRK_EN
  logic       brk = 1'b0;
`endif
  logic       a_a, busy_a, done_a;
  logic [7:0] slot_a;
  logic       a_b, busy_b, done_b;
  logic [7:0] slot_b;

  osc_pattern_gen #(.HALF_PER(2), .BURST(4)) u_dut_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start_a),
    .i_init_lvl (init_lvl),
    .i_abort    (abort),
`ifdef OSC_GEN_BRK_EN
    .i_brk      (brk),
`endif
    .o_a_out    (a_a),
    .o_busy     (busy_a),
    .o_done     (done_a),
    .o_slot_cnt (slot_a)
  );

  osc_pattern_gen #(.HALF_PER(1), .BURST(4)) u_dut_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start_b),
    .i_init_lvl (init_lvl),
    .i_abort    (abort),
`ifdef OSC_GEN_BRK_EN
    .i_brk      (1'b0),
`endif
    .o_a_out    (a_b),
    .o_busy     (busy_b),
    .o_done     (done_b),
    .o_slot_cnt (slot_b)
  );

  typedef struct {
    bit         sel;
    logic       a;
    logic       busy;
    logic       done;
    logic [7:0] slot;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic [10:0] act;

  // Monitor: every negedge with a pending expectation compares the selected DUT.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      act = mon_e.sel ? {a_b, busy_b, done_b, slot_b} : {a_a, busy_a, done_a, slot_a};
      n_vec++;
      if (act !== {mon_e.a, mon_e.busy, mon_e.done, mon_e.slot}) begin
        n_err++;
        $display("FAIL %s vec %0d: got a=%b busy=%b done=%b slot=%0d, want a=%b busy=%b done=%b slot=%0d",
                 mon_e.tag, n_vec, act[10], act[9], act[8], act[7:0],
                 mon_e.a, mon_e.busy, mon_e.done, mon_e.slot);
      end
    end
  end

  // Drive inputs, take one clock edge, then queue the state expected after that edge.
  task automatic step(input bit sel, input logic st, input logic il, input logic ab,
                      input logic rs, input logic ea, input logic eb, input logic ed,
                      input logic [7:0] es, input string tag);
    start_a  = sel ? 1'b0 : st;
    start_b  = sel ? st : 1'b0;
    init_lvl = il;
    abort    = ab;
    rst      = rs;
    @(posedge clk);
    #1;
    sb_q.push_back('{sel: sel, a: ea, busy: eb, done: ed, slot: es, tag: tag});
  endtask

  // Full burst on DUT A from IDLE; hold keeps start high to check restart after done.
  task automatic burst_a(input logic init, input logic hold, input int brk_at);
    logic pa[11] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    logic pb[11] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    logic [7:0] sl[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
    logic ea;
    for (int k = 0; k < 11; k++) begin
`ifdef OSC_GEN_BRK_EN
      brk = (k == brk_at);
`endif
      ea = ((brk_at >= 0) ? pb[k] : pa[k]) ^ init;
      step(0, (k == 0) || hold, init, 0, 0, ea, (k < 10), (k == 10), sl[k], "burst");
    end
`ifdef OSC_GEN_BRK_EN
    brk = 1'b0;
`endif
    ea = ((brk_at >= 0) ? pb[10] : pa[10]) ^ init;
    step(0, hold, init, 0, 0, ea, 0, 0, 8'd4, "idle_after_done");
    if (hold) begin
      step(0, 1, init, 0, 0, init, 1, 0, 8'd0, "restart_after_done");
      step(0, 0, init, 1, 0, init, 0, 0, 8'd0, "abort_restart");
    end
  endtask

  initial begin
    logic pa[11] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    logic [7:0] sl[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
    logic pbb[7] = '{1, 0, 1, 0, 1, 1, 1};

    step(0, 0, 0, 0, 1, 0, 0, 0, 8'd0, "reset_a");
    step(1, 0, 0, 0, 1, 0, 0, 0, 8'd0, "reset_b");

    burst_a(0, 0, -1);
    burst_a(1, 0, -1);

    // Abort on the edge that would otherwise be a slot boundary.
    for (int k = 0; k < 6; k++) begin
      step(0, (k == 0), 0, 0, 0, pa[k], 1, 0, sl[k], "abort_pre");
    end
    step(0, 0, 0, 1, 0, 0, 0, 0, 8'd2, "abort_hold");
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'd2, "abort_no_done");
    step(0, 1, 1, 1, 0, 0, 0, 0, 8'd2, "start_abort_idle");

    // Reset mid-burst, then a fresh burst on the very next edge.
    for (int k = 0; k < 4; k++) begin
      step(0, (k == 0), 0, 0, 0, pa[k], 1, 0, sl[k], "rst_pre");
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 8'd0, "rst_mid_burst");
    burst_a(1, 0, -1);

    burst_a(0, 1, -1);

    // HALF_PER=1 toggles every cycle.
    for (int k = 0; k < 7; k++) begin
      step(1, (k == 0), 1, 0, 0, pbb[k], (k < 5), (k == 5), 8'((k < 4) ? k : 4), "half1");
    end

`ifdef OSC_GEN_BRK_EN
    burst_a(0, 0, 4);
`endif

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osc_pattern_gen.md
OSC_PATTERN_GEN -- requirements
Module: osc_pattern_gen

Interface
REQ-001 Parameter HALF_PER, default 2, SHALL set the clock cycles per output bit slot (legal range 1..255).
REQ-002 Parameter BURST, default 4, SHALL set the number of level toggles per burst (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  input  1  SHALL be the request to begin a burst; sampled only in IDLE.
REQ-006 init_lvl  input  1  SHALL be the first-slot level, captured with start.
REQ-007 abort  input  1  SHALL be the request to terminate a burst in progress.
REQ-008 a_out  output  1  SHALL be the oscillating pattern that drives the detector's A input.
REQ-009 busy  output  1  SHALL be high while in RUN.
REQ-010 done  output  1  SHALL be a one-cycle pulse on normal burst completion.
REQ-011 slot_cnt  output  8  SHALL be the number of completed slot boundaries in the current or most recent burst.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE, start=1, abort=0: SHALL go to RUN next edge with a_out<=init_lvl, phase<=0, slot_cnt<=0, busy<=1.
REQ-014 IDLE, start=1, abort=1: SHALL stay in IDLE with no output change (abort wins).
REQ-015 RUN, phase<HALF_PER-1: SHALL increment phase and hold a_out.
REQ-016 RUN, phase==HALF_PER-1, slot_cnt<BURST: SHALL toggle a_out, increment slot_cnt and clear phase.
REQ-017 RUN, phase==HALF_PER-1, slot_cnt==BURST: SHALL go to DONE with no toggle; busy<=0, done<=1.
REQ-018 Burst timing: SHALL give BURST+1 slots of HALF_PER cycles each, i.e. (BURST+1)*HALF_PER cycles from the start edge to the DONE entry.
REQ-019 DONE: SHALL return to IDLE after exactly one cycle with done<=0; a_out SHALL hold its last level.
REQ-020 RUN, abort=1: SHALL go to IDLE next edge with busy<=0 and no done pulse; a_out and slot_cnt SHALL hold; abort overrides a slot boundary on the same edge.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-022 HALF_PER=1: a_out SHALL toggle every cycle; phase SHALL stay 0.
REQ-023 slot_cnt SHALL not wrap, because BURST is at most 255.

Reset
REQ-024 rst=1 SHALL force IDLE, a_out=0, busy=0, done=0, slot_cnt=0, phase=0 at the next edge, overriding every other input, including mid-burst.
REQ-025 After rst deasserts, the block SHALL accept start on the first following edge.

Configuration
REQ-026 With macro OSC_GEN_BRK_EN defined, the block SHALL add input port brk (1 bit) after abort.
REQ-027 With OSC_GEN_BRK_EN defined: brk=1 at a RUN slot boundary SHALL suppress that toggle (level repeats), while slot_cnt still increments, giving the detector a negative case.
REQ-028 Without OSC_GEN_BRK_EN: no brk port SHALL exist, and every RUN slot boundary below BURST SHALL toggle.

Verification (HALF_PER=2, BURST=4 unless noted)
REQ-029 Start with init_lvl=0 at edge E0 -> a_out SHALL be 0,0,1,1,0,0,1,1,0,0 over cycles E0..E10; done SHALL be high only E10..E11; slot_cnt SHALL end at 4; busy SHALL be high E0..E10.
REQ-030 Start with init_lvl=1, HALF_PER=1 -> a_out SHALL be 1,0,1,0,1 on consecutive cycles, then hold 1; done SHALL pulse at E5.
REQ-031 abort at E5 -> a_out SHALL hold 0, slot_cnt=2, busy=0 at E6, and done SHALL never assert.
REQ-032 rst at E3 mid-burst -> a_out=0, busy=0, slot_cnt=0 at E4; start at E5 SHALL begin a fresh burst.
REQ-033 start held high through the whole burst -> exactly one burst until IDLE, then a second burst SHALL start on the edge after done.
REQ-034 OSC_GEN_BRK_EN defined, brk=1 at E4 -> a_out SHALL be 0,0,1,1,1,1,0,0,1,1; slot_cnt SHALL end at 4.
